// File: rtl/gpu_mem_responder.sv
`default_nettype none
// gpu_mem_responder: byte-wide memory slave with zero-wait writes and a fixed-latency, waitrequest-stalled read path.
// Optional GPU_MEM_WAIT_INJECT_EN adds LFSR-driven random stalls in IDLE.  Revision: 1.0
module gpu_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          DEPTH        = 4096,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s1_address,
    input  logic        s1_read,
    input  logic        s1_write,
    input  logic [7:0]  s1_writedata,
    output logic [7:0]  s1_readdata,
    output logic        s1_readdatavalid,
    output logic        s1_waitrequest,
    input  logic        clear_errors,
    output logic        range_error,
    output logic        protocol_error
);
    localparam int         ADDR_BITS = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RD_RESP = 2'd2;
    localparam logic [3:0] LAT_LOAD  = 4'(READ_LATENCY - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] offset_q, offset_d;
    logic                 oor_q, oor_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 range_q, protocol_q;
    logic                 range_set, protocol_set;
    logic [7:0]           ram_q [DEPTH];

    logic [31:0] offset;
    logic        in_range;
    logic        idle;
    logic        stall;
    logic        rd_accept;
    logic        wr_accept;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets.
    assign offset    = s1_address - BASE_ADDR;
    assign in_range  = (offset < 32'(DEPTH));
    assign idle      = (state_q == S_IDLE);
    assign rd_accept = idle & s1_read & ~stall & ~reset;
    assign wr_accept = idle & s1_write & ~s1_read & ~stall & ~reset;

`ifdef GPU_MEM_WAIT_INJECT_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (wr_accept && in_range) begin
            ram_q[offset[ADDR_BITS-1:0]] <= s1_writedata;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        offset_d     = offset_q;
        oor_d        = oor_q;
        rdata_d      = rdata_q;
        range_set    = 1'b0;
        protocol_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_accept) begin
                    state_d      = S_RD_WAIT;
                    cnt_d        = LAT_LOAD;
                    offset_d     = offset[ADDR_BITS-1:0];
                    oor_d        = ~in_range;
                    range_set    = ~in_range;
                    protocol_set = s1_write;
                end else if (wr_accept) begin
                    range_set = ~in_range;
                end
            end
            S_RD_WAIT: begin
                // A master that drops read while stalled has broken the handshake.
                if (!s1_read) begin
                    state_d      = S_IDLE;
                    protocol_set = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RD_RESP;
                    rdata_d = oor_q ? 8'hFF : ram_q[offset_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            offset_q   <= '0;
            oor_q      <= 1'b0;
            rdata_q    <= 8'h00;
            range_q    <= 1'b0;
            protocol_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            offset_q   <= offset_d;
            oor_q      <= oor_d;
            rdata_q    <= rdata_d;
            range_q    <= (range_q & ~clear_errors) | range_set;
            protocol_q <= (protocol_q & ~clear_errors) | protocol_set;
        end
    end

    assign s1_readdata      = rdata_q;
    assign s1_readdatavalid = ~reset & (state_q == S_RD_RESP);
    assign s1_waitrequest   = ~reset & ((idle & (s1_read | stall)) | (state_q == S_RD_WAIT));
    assign range_error      = range_q;
    assign protocol_error   = protocol_q;

endmodule
`default_nettype wire
